// File: rtl/cordic_rotation_engine.sv
// CORDIC rotation engine: pops shift-add micro-ops from the CORDIC FIFO, rotates an
// internal (x, y) vector, applies quadrant/swap correction and emits saturated cos/sin.
module cordic_rotation_engine (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iFifo_empty,
  input  logic [10:0] iFifo_data,
  output logic        oFifo_read_request,
  input  logic        iOut_ready,
  output logic        oValid,
  output logic [15:0] oCos,
  output logic [15:0] oSin,
  output logic        oBusy
);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_CORRECT,
    ST_OUT
  } state_e;

  localparam logic signed [17:0] X_INIT  = 18'sd19899;
  localparam logic signed [17:0] SAT_MAX = 18'sd32767;
  localparam logic signed [17:0] SAT_MIN = -18'sd32768;

  state_e             state_q, state_d;
  logic signed [17:0] x_q, x_d;
  logic signed [17:0] y_q, y_d;
  logic [2:0]         info_q, info_d;
  logic [15:0]        cos_q, cos_d;
  logic [15:0]        sin_q, sin_d;
  logic               busy_q, busy_d;
  logic               rd_req;

  logic signed [17:0] x_sh, y_sh;
  logic signed [17:0] c_sw, s_sw;
  logic signed [17:0] c_fin, s_fin;

  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    if (v > SAT_MAX) begin
      return 16'h7FFF;
    end else if (v < SAT_MIN) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    info_d  = info_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    busy_d  = busy_q;
    rd_req  = 1'b0;

    x_sh = x_q >>> iFifo_data[3:0];
    y_sh = y_q >>> iFifo_data[3:0];

    // info_q = {swap, q}; swap selects whether x or y carries the cosine
    c_sw = info_q[2] ? y_q : x_q;
    s_sw = info_q[2] ? x_q : y_q;
    unique case (info_q[1:0])
      2'd0: begin c_fin = c_sw;  s_fin = s_sw;  end
      2'd1: begin c_fin = -s_sw; s_fin = c_sw;  end
      2'd2: begin c_fin = -c_sw; s_fin = -s_sw; end
      default: begin c_fin = s_sw; s_fin = -c_sw; end
    endcase

    unique case (state_q)
      ST_FETCH: begin
        if (!iFifo_empty) begin
          rd_req  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy_d = 1'b1;
        if (iFifo_data[6:5] != 2'b10) begin
          if (iFifo_data[4]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
          end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
          end
        end
        if (iFifo_data[6:5] == 2'b00) begin
          state_d = ST_FETCH;
        end else begin
          // reserved bit [10] is masked off rather than dropped so every input bit is consumed
          info_d  = 3'(iFifo_data[10:7] & 4'b0111);
          state_d = ST_CORRECT;
        end
      end
      ST_CORRECT: begin
        cos_d   = sat16(c_fin);
        sin_d   = sat16(s_fin);
        state_d = ST_OUT;
      end
      default: begin
        if (iOut_ready) begin
          x_d     = X_INIT;
          y_d     = '0;
          busy_d  = 1'b0;
          state_d = ST_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= ST_FETCH;
      x_q     <= X_INIT;
      y_q     <= '0;
      info_q  <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      info_q  <= info_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      busy_q  <= busy_d;
    end
  end

  assign oFifo_read_request = rd_req;
  assign oValid             = (state_q == ST_OUT);
  assign oCos               = cos_q;
  assign oSin               = sin_q;
  assign oBusy              = busy_q;

endmodule

// File: tb/tb_cordic_rotation_engine.sv
// Directed bench for cordic_rotation_engine with a small FIFO model and hand-computed results.
module tb_cordic_rotation_engine;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iFifo_empty;
  logic [10:0] iFifo_data;
  logic        oFifo_read_request;
  logic        iOut_ready;
  logic        oValid;
  logic [15:0] oCos;
  logic [15:0] oSin;
  logic        oBusy;

  cordic_rotation_engine dut (
    .iClk              (iClk),
    .iReset            (iReset),
    .iFifo_empty       (iFifo_empty),
    .iFifo_data        (iFifo_data),
    .oFifo_read_request(oFifo_read_request),
    .iOut_ready        (iOut_ready),
    .oValid            (oValid),
    .oCos              (oCos),
    .oSin              (oSin),
    .oBusy             (oBusy)
  );

  always #5 iClk = ~iClk;

  int          cyc = 0;
  int          pop_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [10:0] fifo[$];
  logic        pop;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] w(input logic [3:0] info, input logic [1:0] code,
                                    input logic sgn, input logic [3:0] idx);
    return {info, code, sgn, idx};
  endfunction

  // FIFO model: a pop requested in a cycle yields data in the following cycle
  initial begin
    iFifo_empty = 1'b1;
    iFifo_data  = '0;
    forever begin
      @(negedge iClk);
      pop = oFifo_read_request;
      if (pop === 1'b1) pop_cyc = cyc;
      @(posedge iClk);
      #1;
      if (pop === 1'b1 && fifo.size() > 0) iFifo_data = fifo.pop_front();
      iFifo_empty = (fifo.size() == 0);
    end
  end

  task automatic wait_result(input string tag, input int exp_cos, input int exp_sin);
    for (int k = 0; k < 60 && oValid !== 1'b1; k++) @(negedge iClk);
    if (oValid !== 1'b1) begin
      check_val({tag, "_timeout"}, 0, 1);
      return;
    end
    check_val({tag, "_cos"}, int'($signed(oCos)), exp_cos);
    check_val({tag, "_sin"}, int'($signed(oSin)), exp_sin);
    check_val({tag, "_latency"}, cyc - pop_cyc, 3);
    check_val({tag, "_busy"}, int'(oBusy), 1);
  endtask

  task automatic accept(input string tag);
    iOut_ready = 1'b1;
    @(negedge iClk);
    iOut_ready = 1'b0;
    check_val({tag, "_valid_drop"}, int'(oValid), 0);
    check_val({tag, "_busy_drop"}, int'(oBusy), 0);
  endtask

  initial begin
    int hold_cos, hold_sin;
    iReset     = 1'b1;
    iOut_ready = 1'b0;
    repeat (3) @(negedge iClk);
    check_val("rst_valid", int'(oValid), 0);
    check_val("rst_cos", int'(oCos), 0);
    check_val("rst_sin", int'(oSin), 0);
    check_val("rst_busy", int'(oBusy), 0);
    check_val("rst_rd", int'(oFifo_read_request), 0);
    iReset = 1'b0;
    @(negedge iClk);

    fifo.push_back(w(4'b0000, 2'b10, 1'b0, 4'd0));
    wait_result("single", 19899, 0);
    accept("single");

    fifo.push_back(w(4'b0000, 2'b00, 1'b0, 4'd0));
    fifo.push_back(w(4'b0000, 2'b01, 1'b1, 4'd1));
    wait_result("q0", 29848, 9950);
    accept("q0");

    fifo.push_back(w(4'b0000, 2'b00, 1'b0, 4'd0));
    fifo.push_back(w(4'b1010, 2'b11, 1'b1, 4'd1));
    wait_result("q2_rsv", -29848, -9950);
    accept("q2_rsv");

    fifo.push_back(w(4'b0000, 2'b00, 1'b0, 4'd0));
    fifo.push_back(w(4'b0101, 2'b01, 1'b1, 4'd1));
    wait_result("swap_q1", -29848, 9950);
    accept("swap_q1");

    fifo.push_back(w(4'b0000, 2'b00, 1'b0, 4'd0));
    fifo.push_back(w(4'b0000, 2'b01, 1'b0, 4'd0));
    wait_result("sat_pos", 0, 32767);
    accept("sat_pos");

    fifo.push_back(w(4'b0000, 2'b00, 1'b0, 4'd0));
    fifo.push_back(w(4'b0010, 2'b01, 1'b0, 4'd0));
    wait_result("sat_neg", 0, -32768);
    accept("sat_neg");

    // backpressure: result held while the FIFO has work queued
    fifo.push_back(w(4'b0000, 2'b00, 1'b0, 4'd0));
    fifo.push_back(w(4'b0000, 2'b01, 1'b1, 4'd1));
    wait_result("bp", 29848, 9950);
    fifo.push_back(w(4'b0000, 2'b10, 1'b0, 4'd0));
    hold_cos = int'($signed(oCos));
    hold_sin = int'($signed(oSin));
    for (int k = 0; k < 5; k++) begin
      @(negedge iClk);
      check_val("bp_valid_hold", int'(oValid), 1);
      check_val("bp_rd_blocked", int'(oFifo_read_request), 0);
      check_val("bp_cos_stable", int'($signed(oCos)), hold_cos);
      check_val("bp_sin_stable", int'($signed(oSin)), hold_sin);
    end
    iOut_ready = 1'b1;
    @(negedge iClk);
    iOut_ready = 1'b0;
    check_val("bp_valid_drop", int'(oValid), 0);
    check_val("bp_pop_next", int'(oFifo_read_request), 1);
    wait_result("bp_next", 19899, 0);
    accept("bp_next");

    // reset mid-angle discards the partial rotation
    fifo.push_back(w(4'b0000, 2'b00, 1'b0, 4'd0));
    for (int k = 0; k < 20 && oBusy !== 1'b1; k++) @(negedge iClk);
    check_val("mid_busy", int'(oBusy), 1);
    iReset = 1'b1;
    @(negedge iClk);
    check_val("mid_rst_valid", int'(oValid), 0);
    check_val("mid_rst_cos", int'(oCos), 0);
    check_val("mid_rst_sin", int'(oSin), 0);
    check_val("mid_rst_busy", int'(oBusy), 0);
    iReset = 1'b0;
    fifo.push_back(w(4'b0000, 2'b10, 1'b0, 4'd0));
    wait_result("post_rst", 19899, 0);
    accept("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
